// File: rtl/datapath_execute_pkg.sv
// Shared encodings and record layouts for the execute stage.
package datapath_execute_pkg;

   localparam int ID_EX_WIDTH = 99;
   localparam int EX_WB_WIDTH = 87;

   // EX_WB field offsets (LSB of each field)
   localparam int EXWB_INSTR_LSB     = 0;
   localparam int EXWB_PC_LSB        = 16;
   localparam int EXWB_RESULT_LSB    = 32;
   localparam int EXWB_MEM_WDATA_LSB = 48;
   localparam int EXWB_MEM_ADDR_LSB  = 64;
   localparam int EXWB_MEM_WR_BIT    = 80;
   localparam int EXWB_MEM_RD_BIT    = 81;
   localparam int EXWB_WB_REG_LSB    = 82;
   localparam int EXWB_WB_EN_BIT     = 85;
   localparam int EXWB_WB_FROM_MEM   = 86;

   // Opcodes (instr[3:0])
   localparam logic [3:0] OP_MV   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_CMP  = 4'b0011;
   localparam logic [3:0] OP_LD   = 4'b0100;
   localparam logic [3:0] OP_ST   = 4'b0101;
   localparam logic [3:0] OP_MVHI = 4'b0110;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_JZ   = 4'b1001;
   localparam logic [3:0] OP_JN   = 4'b1010;
   localparam logic [3:0] OP_CALL = 4'b1100;

   // ALU operation select
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   typedef struct packed {
      logic [2:0]  alu_op;
      logic [15:0] imm8;
      logic [15:0] imm11;
      logic [15:0] data1;
      logic [15:0] data2;
      logic [15:0] pc;
      logic [15:0] instr;
   } id_ex_t;

   typedef struct packed {
      logic        wb_from_mem;
      logic        wb_en;
      logic [2:0]  wb_reg;
      logic        mem_rd;
      logic        mem_wr;
      logic [15:0] mem_addr;
      logic [15:0] mem_wdata;
      logic [15:0] result;
      logic [15:0] pc;
      logic [15:0] instr;
   } ex_wb_t;

endpackage

// File: rtl/datapath_execute_alu.sv
// Combinational 16-bit add/subtract unit with zero/negative outputs.
module exec_alu
   import datapath_execute_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [2:0]  alu_op,
   output logic [15:0] result,
   output logic        z,
   output logic        n
);

   // Wrapping add/subtract; carry and borrow are discarded
   always_comb begin
      result = (alu_op == ALU_SUB) ? (a - b) : (a + b);
      z      = (result == '0);
      n      = result[15];
   end

endmodule

// File: rtl/datapath_execute.sv
// Execute stage: ALU, Z/N flags, jump resolution, memory request forming, EX_WB register.
module datapath_execute
   import datapath_execute_pkg::*;
#(
   parameter logic [2:0] LINK_REG = 3'd7
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ID_EX_WIDTH-1:0] ID_EX,
   input  logic                   id_ex_valid,
   input  logic                   stall,
   output logic [EX_WB_WIDTH-1:0] EX_WB,
   output logic                   flag_z,
   output logic                   flag_n,
   output logic                   branch_taken,
   output logic [15:0]            branch_target
);

   id_ex_t      id;
   ex_wb_t      ex_next;
   ex_wb_t      ex_q;
   logic [3:0]  opcode;
   logic        imm_sel;
   logic [2:0]  rx;
   logic [15:0] operand_b;
   logic [15:0] alu_result;
   logic        alu_z;
   logic        alu_n;
   logic        flag_upd;
   logic        jump_cond;
   logic        op_known;

   assign id        = ID_EX;
   assign opcode    = id.instr[3:0];
   assign imm_sel   = id.instr[4];
   assign rx        = id.instr[7:5];
   assign operand_b = imm_sel ? id.imm8 : id.data2;

   exec_alu u_alu (
      .a      (id.data1),
      .b      (operand_b),
      .alu_op (id.alu_op),
      .result (alu_result),
      .z      (alu_z),
      .n      (alu_n)
   );

   // Decode opcode into the next EX_WB record, flag-update enable and jump condition
   always_comb begin
      ex_next       = '0;
      flag_upd      = 1'b0;
      jump_cond     = 1'b0;
      op_known      = 1'b1;
      ex_next.pc    = id.pc;
      ex_next.instr = id.instr;
      case (opcode)
         OP_MV: begin
            ex_next.wb_en  = 1'b1;
            ex_next.wb_reg = rx;
            ex_next.result = operand_b;
         end
         OP_ADD, OP_SUB: begin
            ex_next.wb_en  = 1'b1;
            ex_next.wb_reg = rx;
            ex_next.result = alu_result;
            flag_upd       = 1'b1;
         end
         OP_CMP: begin
            flag_upd = 1'b1;
         end
         OP_MVHI: begin
            ex_next.wb_en  = 1'b1;
            ex_next.wb_reg = rx;
            ex_next.result = {id.imm8[7:0], id.data1[7:0]};
         end
         OP_LD: begin
            ex_next.mem_rd      = 1'b1;
            ex_next.mem_addr    = id.data2;
            ex_next.wb_from_mem = 1'b1;
            ex_next.wb_en       = 1'b1;
            ex_next.wb_reg      = rx;
         end
         OP_ST: begin
            ex_next.mem_wr    = 1'b1;
            ex_next.mem_addr  = id.data2;
            ex_next.mem_wdata = id.data1;
         end
         OP_J:  jump_cond = 1'b1;
         OP_JZ: jump_cond = flag_z;
         OP_JN: jump_cond = flag_n;
         OP_CALL: begin
            jump_cond      = 1'b1;
            ex_next.wb_en  = 1'b1;
            ex_next.wb_reg = LINK_REG;
            ex_next.result = id.pc;
         end
         default: op_known = 1'b0;
      endcase
      // unknown opcodes collapse to a full bubble record
      if (!op_known) begin
         ex_next = '0;
      end
   end

   // Redirect to fetch; suppressed by reset, stall and bubbles
   always_comb begin
      branch_target = imm_sel ? (id.pc + (id.imm11 << 1)) : id.data1;
      branch_taken  = ~reset & id_ex_valid & ~stall & jump_cond;
   end

   // EX_WB and Z/N flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q   <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (stall) begin
         ex_q   <= ex_q;
      end else if (!id_ex_valid) begin
         ex_q   <= '0;
      end else begin
         ex_q <= ex_next;
         if (flag_upd) begin
            flag_z <= alu_z;
            flag_n <= alu_n;
         end
      end
   end

   assign EX_WB = ex_q;

endmodule

// File: tb/tb_datapath_execute.sv
// Directed table-driven bench for the execute stage.
module tb_datapath_execute;
   import datapath_execute_pkg::*;

   logic                   clk;
   logic                   reset;
   logic [ID_EX_WIDTH-1:0] ID_EX;
   logic                   id_ex_valid;
   logic                   stall;
   logic [EX_WB_WIDTH-1:0] EX_WB;
   logic                   flag_z;
   logic                   flag_n;
   logic                   branch_taken;
   logic [15:0]            branch_target;

   int total = 0;
   int bad   = 0;

   datapath_execute #(.LINK_REG(3'd7)) dut (
      .clk           (clk),
      .reset         (reset),
      .ID_EX         (ID_EX),
      .id_ex_valid   (id_ex_valid),
      .stall         (stall),
      .EX_WB         (EX_WB),
      .flag_z        (flag_z),
      .flag_n        (flag_n),
      .branch_taken  (branch_taken),
      .branch_target (branch_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   typedef struct packed {
      logic [98:0] id_ex;
      logic        valid;
      logic [86:0] exp_ewb;
      logic        exp_z;
      logic        exp_n;
      logic        exp_taken;
      logic        chk_tgt;
      logic [15:0] exp_tgt;
   } vec_t;

   localparam int NV = 15;
   vec_t tv [NV];

   function automatic logic [15:0] ins(input logic [3:0] op, input logic imm,
                                       input logic [2:0] rx, input logic [2:0] ry);
      return {5'b0, ry, rx, imm, op};
   endfunction

   function automatic logic [98:0] idx(input logic [2:0] alu, input logic [15:0] imm8,
                                       input logic [15:0] imm11, input logic [15:0] d1,
                                       input logic [15:0] d2, input logic [15:0] pc,
                                       input logic [15:0] instr);
      return {alu, imm8, imm11, d1, d2, pc, instr};
   endfunction

   function automatic logic [86:0] ew(input logic fm, input logic we, input logic [2:0] wr,
                                      input logic rd, input logic wm, input logic [15:0] addr,
                                      input logic [15:0] wdata, input logic [15:0] res,
                                      input logic [15:0] pc, input logic [15:0] instr);
      return {fm, we, wr, rd, wm, addr, wdata, res, pc, instr};
   endfunction

   function automatic vec_t mk(input logic [98:0] id_ex, input logic valid,
                               input logic [86:0] e, input logic z, input logic n,
                               input logic tk, input logic ct, input logic [15:0] tg);
      vec_t v;
      v.id_ex = id_ex; v.valid = valid; v.exp_ewb = e; v.exp_z = z; v.exp_n = n;
      v.exp_taken = tk; v.chk_tgt = ct; v.exp_tgt = tg;
      return v;
   endfunction

   task automatic chk(input string name, input int idn, input logic [86:0] act,
                      input logic [86:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", name, idn, act, exp);
      end
   endtask

   task automatic check_regs(input string tag, input int idn, input logic [86:0] e,
                             input logic z, input logic n);
      chk({tag, "_ewb"}, idn, EX_WB, e);
      chk({tag, "_z"}, idn, 87'(flag_z), 87'(z));
      chk({tag, "_n"}, idn, 87'(flag_n), 87'(n));
   endtask

   logic [15:0] i;
   logic [86:0] hold_ewb;

   initial begin
      // ---------- vector table ----------
      i = ins(OP_ADD, 1'b1, 3'd1, 3'd0);
      tv[0]  = mk(idx(ALU_ADD, 16'h0001, 16'h0000, 16'h7FFF, 16'h0000, 16'h0002, i), 1'b1,
                  ew(0, 1, 3'd1, 0, 0, 16'h0, 16'h0, 16'h8000, 16'h0002, i), 0, 1, 0, 0, 16'h0);
      i = ins(OP_CMP, 1'b0, 3'd2, 3'd3);
      tv[1]  = mk(idx(ALU_SUB, 16'h0000, 16'h0000, 16'h0005, 16'h0005, 16'h0004, i), 1'b1,
                  ew(0, 0, 3'd0, 0, 0, 16'h0, 16'h0, 16'h0000, 16'h0004, i), 1, 0, 0, 0, 16'h0);
      i = ins(OP_JZ, 1'b1, 3'd0, 3'd0);
      tv[2]  = mk(idx(ALU_ADD, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 16'h0010, i), 1'b1,
                  ew(0, 0, 3'd0, 0, 0, 16'h0, 16'h0, 16'h0000, 16'h0010, i), 1, 0, 1, 1, 16'h000C);
      i = ins(OP_JN, 1'b1, 3'd0, 3'd0);
      tv[3]  = mk(idx(ALU_ADD, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 16'h0012, i), 1'b1,
                  ew(0, 0, 3'd0, 0, 0, 16'h0, 16'h0, 16'h0000, 16'h0012, i), 1, 0, 0, 0, 16'h0);
      i = ins(OP_LD, 1'b0, 3'd4, 3'd5);
      tv[4]  = mk(idx(ALU_ADD, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0014, i), 1'b1,
                  ew(1, 1, 3'd4, 1, 0, 16'h1234, 16'h0, 16'h0000, 16'h0014, i), 1, 0, 0, 0, 16'h0);
      i = ins(OP_ST, 1'b0, 3'd6, 3'd1);
      tv[5]  = mk(idx(ALU_ADD, 16'h0000, 16'h0000, 16'hBEEF, 16'h0040, 16'h0016, i), 1'b1,
                  ew(0, 0, 3'd0, 0, 1, 16'h0040, 16'hBEEF, 16'h0000, 16'h0016, i), 1, 0, 0, 0, 16'h0);
      i = ins(OP_MV, 1'b1, 3'd3, 3'd0);
      tv[6]  = mk(idx(ALU_ADD, 16'hFF80, 16'h0000, 16'h1111, 16'h2222, 16'h0018, i), 1'b1,
                  ew(0, 1, 3'd3, 0, 0, 16'h0, 16'h0, 16'hFF80, 16'h0018, i), 1, 0, 0, 0, 16'h0);
      i = ins(OP_MVHI, 1'b1, 3'd5, 3'd0);
      tv[7]  = mk(idx(ALU_ADD, 16'h00AB, 16'h0000, 16'h1234, 16'h0000, 16'h001A, i), 1'b1,
                  ew(0, 1, 3'd5, 0, 0, 16'h0, 16'h0, 16'hAB34, 16'h001A, i), 1, 0, 0, 0, 16'h0);
      i = ins(OP_SUB, 1'b0, 3'd1, 3'd2);
      tv[8]  = mk(idx(ALU_SUB, 16'h0000, 16'h0000, 16'h0003, 16'h0005, 16'h001C, i), 1'b1,
                  ew(0, 1, 3'd1, 0, 0, 16'h0, 16'h0, 16'hFFFE, 16'h001C, i), 0, 1, 0, 0, 16'h0);
      i = ins(OP_JN, 1'b0, 3'd3, 3'd0);
      tv[9]  = mk(idx(ALU_ADD, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h001E, i), 1'b1,
                  ew(0, 0, 3'd0, 0, 0, 16'h0, 16'h0, 16'h0000, 16'h001E, i), 0, 1, 1, 1, 16'h0400);
      i = ins(OP_CALL, 1'b0, 3'd2, 3'd0);
      tv[10] = mk(idx(ALU_ADD, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 16'h0032, i), 1'b1,
                  ew(0, 1, 3'd7, 0, 0, 16'h0, 16'h0, 16'h0032, 16'h0032, i), 0, 1, 1, 1, 16'h0200);
      i = ins(OP_ADD, 1'b0, 3'd1, 3'd2);
      tv[11] = mk(idx(ALU_ADD, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0034, i), 1'b0,
                  '0, 0, 1, 0, 0, 16'h0);
      i = ins(4'b0111, 1'b1, 3'd1, 3'd1);
      tv[12] = mk(idx(ALU_ADD, 16'h0001, 16'h0000, 16'hFFFF, 16'h0001, 16'h0036, i), 1'b1,
                  '0, 0, 1, 0, 0, 16'h0);
      i = ins(OP_ADD, 1'b0, 3'd1, 3'd2);
      tv[13] = mk(idx(ALU_ADD, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0038, i), 1'b1,
                  ew(0, 1, 3'd1, 0, 0, 16'h0, 16'h0, 16'h0000, 16'h0038, i), 1, 0, 0, 0, 16'h0);
      i = ins(OP_JZ, 1'b0, 3'd4, 3'd0);
      tv[14] = mk(idx(ALU_ADD, 16'h0000, 16'h0000, 16'h0300, 16'h0000, 16'h003A, i), 1'b1,
                  ew(0, 0, 3'd0, 0, 0, 16'h0, 16'h0, 16'h0000, 16'h003A, i), 1, 0, 1, 1, 16'h0300);

      // ---------- reset with live stimulus ----------
      reset = 1'b1; stall = 1'b0; id_ex_valid = 1'b1;
      ID_EX = tv[0].id_ex;
      @(posedge clk); #1;
      ID_EX = idx(ALU_ADD, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0002, ins(OP_J, 1'b0, 3'd0, 3'd0));
      #2;
      chk("rst_taken", 0, 87'(branch_taken), 87'(0));
      @(posedge clk); #1;
      check_regs("rst", 0, '0, 1'b0, 1'b0);
      reset = 1'b0;

      // ---------- table ----------
      for (int k = 0; k < NV; k++) begin
         ID_EX = tv[k].id_ex;
         id_ex_valid = tv[k].valid;
         stall = 1'b0;
         #2;
         chk("taken", k, 87'(branch_taken), 87'(tv[k].exp_taken));
         if (tv[k].chk_tgt) chk("target", k, 87'(branch_target), 87'(tv[k].exp_tgt));
         @(posedge clk); #1;
         check_regs("vec", k, tv[k].exp_ewb, tv[k].exp_z, tv[k].exp_n);
      end

      // ---------- stall: a jz whose condition holds, then a queued subi ----------
      hold_ewb = tv[14].exp_ewb;
      stall = 1'b1; id_ex_valid = 1'b1;
      ID_EX = idx(ALU_ADD, 16'h0, 16'h0, 16'h0500, 16'h0, 16'h003C, ins(OP_JZ, 1'b0, 3'd1, 3'd0));
      #2;
      chk("stall_jz_taken", 0, 87'(branch_taken), 87'(0));
      @(posedge clk); #1;
      check_regs("stall_jz", 0, hold_ewb, 1'b1, 1'b0);
      i = ins(OP_SUB, 1'b1, 3'd2, 3'd0);
      ID_EX = idx(ALU_SUB, 16'h0003, 16'h0, 16'h0001, 16'h0, 16'h003C, i);
      #2;
      chk("stall_sub_taken", 0, 87'(branch_taken), 87'(0));
      @(posedge clk); #1;
      check_regs("stall_sub", 0, hold_ewb, 1'b1, 1'b0);
      stall = 1'b0;
      @(posedge clk); #1;
      check_regs("unstall_sub", 0, ew(0, 1, 3'd2, 0, 0, 16'h0, 16'h0, 16'hFFFE, 16'h003C, i),
                 1'b0, 1'b1);

      // ---------- reset mid-stream overrides stall and valid ----------
      reset = 1'b1; stall = 1'b1; id_ex_valid = 1'b1;
      ID_EX = idx(ALU_ADD, 16'h0, 16'h0, 16'h0600, 16'h0, 16'h003E, ins(OP_JN, 1'b0, 3'd0, 3'd0));
      #2;
      chk("midrst_taken", 0, 87'(branch_taken), 87'(0));
      @(posedge clk); #1;
      check_regs("midrst", 0, '0, 1'b0, 1'b0);
      reset = 1'b0; stall = 1'b0; id_ex_valid = 1'b0;
      @(posedge clk); #1;
      check_regs("post_rst_bubble", 0, '0, 1'b0, 1'b0);
      id_ex_valid = 1'b1;
      i = ins(OP_ADD, 1'b0, 3'd6, 3'd2);
      ID_EX = idx(ALU_ADD, 16'h0, 16'h0, 16'h0002, 16'h0003, 16'h0040, i);
      @(posedge clk); #1;
      check_regs("post_rst_add", 0, ew(0, 1, 3'd6, 0, 0, 16'h0, 16'h0, 16'h0005, 16'h0040, i),
                 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
